// File: rtl/atomic_alu_pkg.sv
// Shared types and opcode constants for the atomic ALU controller.
// The state encoding is visible to every file that imports this package.
package atomic_alu_pkg;

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        EXEC     = 3'd1,
        CAS_CMP  = 3'd2,
        CAS_SWAP = 3'd3,
        DONE     = 3'd4
    } state_t;

    localparam logic [2:0] OP_ADD = 3'b000;
    localparam logic [2:0] OP_SUB = 3'b001;
    localparam logic [2:0] OP_AND = 3'b010;
    localparam logic [2:0] OP_OR  = 3'b011;
    localparam logic [2:0] OP_XOR = 3'b100;
    localparam logic [2:0] OP_CAS = 3'b111;

endpackage

// File: rtl/param_atomic_controller_if.sv
// Command handshake and external ALU bus for param_atomic_controller.
// slave is the controller side, master is the host/ALU side.
interface param_atomic_controller_if #(
    parameter int DATA_W = 32,
    parameter int NREGS  = 8
) ();
    localparam int AW    = $clog2(NREGS);
    localparam int CMD_W = 3 + 3 * AW;

    logic              cmd_valid;
    logic              cmd_ready;
    logic [CMD_W-1:0]  cmd;
    logic [2:0]        alu_op;
    logic [DATA_W-1:0] alu_a;
    logic [DATA_W-1:0] alu_b;
    logic [DATA_W-1:0] alu_y;
    logic              alu_z;
    logic              done;
    logic              cas_success;

    modport slave (
        input  cmd_valid, cmd, alu_y, alu_z,
        output cmd_ready, alu_op, alu_a, alu_b, done, cas_success
    );

    modport master (
        output cmd_valid, cmd, alu_y, alu_z,
        input  cmd_ready, alu_op, alu_a, alu_b, done, cas_success
    );
endinterface

// File: rtl/param_regfile.sv
// Register file: three combinational read ports, two write ports, async clear.
// Port B exists only so a swap can update two registers on one edge.
module param_regfile #(
    parameter int DATA_W = 32,
    parameter int NREGS  = 8
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [$clog2(NREGS)-1:0] ra0,
    input  logic [$clog2(NREGS)-1:0] ra1,
    input  logic [$clog2(NREGS)-1:0] ra2,
    output logic [DATA_W-1:0]        rd0,
    output logic [DATA_W-1:0]        rd1,
    output logic [DATA_W-1:0]        rd2,
    input  logic                     we_a,
    input  logic [$clog2(NREGS)-1:0] wa_a,
    input  logic [DATA_W-1:0]        wd_a,
    input  logic                     we_b,
    input  logic [$clog2(NREGS)-1:0] wa_b,
    input  logic [DATA_W-1:0]        wd_b,
    output logic [DATA_W-1:0]        last_q
);
    logic [DATA_W-1:0] regs [NREGS];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < NREGS; i++) begin
                regs[i] <= '0;
            end
        end else begin
            if (we_a) regs[wa_a] <= wd_a;
            if (we_b) regs[wa_b] <= wd_b;
        end
    end

    assign rd0    = regs[ra0];
    assign rd1    = regs[ra1];
    assign rd2    = regs[ra2];
    assign last_q = regs[NREGS-1];
endmodule

// File: rtl/param_atomic_controller.sv
// Command sequencer driving an external ALU: plain ALU ops write R[a3],
// CAS compares R[a1]/R[a2] and on match swaps R[a1] with R[a3].
module param_atomic_controller
    import atomic_alu_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int NREGS  = 8
) (
    input  logic                     clk,
    input  logic                     rst_n,
    param_atomic_controller_if.slave bus,
    input  logic                     wr_en,
    input  logic [$clog2(NREGS)-1:0] wr_addr,
    input  logic [DATA_W-1:0]        wr_data,
    output logic [DATA_W-1:0]        reg_last
);
    localparam int AW    = $clog2(NREGS);
    localparam int CMD_W = 3 + 3 * AW;

    state_t            state;
    logic [2:0]        opcode;
    logic [AW-1:0]     a1, a2, a3;
    logic              match;
    logic              rdy_q, done_q, cas_q;
    logic              accept;
    logic [CMD_W-1:0]  cmd_w;

    logic [DATA_W-1:0] rd0, rd1, rd2;
    logic              we_a, we_b;
    logic [AW-1:0]     wa_a, wa_b;
    logic [DATA_W-1:0] wd_a, wd_b;

    assign cmd_w           = bus.cmd;
    assign accept          = bus.cmd_valid && rdy_q;
    assign bus.cmd_ready   = rdy_q;
    assign bus.done        = done_q;
    assign bus.cas_success = cas_q;

    // ALU drive and write-port steering; reads always see pre-edge contents.
    always_comb begin
        bus.alu_op = '0;
        bus.alu_a  = '0;
        bus.alu_b  = '0;
        we_a       = 1'b0;
        wa_a       = '0;
        wd_a       = '0;
        we_b       = 1'b0;
        wa_b       = '0;
        wd_b       = '0;
        case (state)
            IDLE: begin
                we_a = wr_en;
                wa_a = wr_addr;
                wd_a = wr_data;
            end
            EXEC: begin
                bus.alu_op = opcode;
                bus.alu_a  = rd0;
                bus.alu_b  = rd1;
                we_a       = 1'b1;
                wa_a       = a3;
                wd_a       = bus.alu_y;
            end
            CAS_CMP: begin
                bus.alu_op = OP_SUB;
                bus.alu_a  = rd0;
                bus.alu_b  = rd1;
            end
            CAS_SWAP: begin
                if (match && (a1 != a3)) begin
                    we_a = 1'b1;
                    wa_a = a1;
                    wd_a = rd2;
                    we_b = 1'b1;
                    wa_b = a3;
                    wd_b = rd0;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= IDLE;
            opcode <= '0;
            a1     <= '0;
            a2     <= '0;
            a3     <= '0;
            match  <= 1'b0;
            rdy_q  <= 1'b0;
            done_q <= 1'b0;
            cas_q  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    rdy_q <= 1'b1;
                    if (accept) begin
                        opcode <= cmd_w[CMD_W-1 -: 3];
                        a1     <= cmd_w[3*AW-1 -: AW];
                        a2     <= cmd_w[2*AW-1 -: AW];
                        a3     <= cmd_w[AW-1:0];
                        rdy_q  <= 1'b0;
                        state  <= (cmd_w[CMD_W-1 -: 3] == OP_CAS) ? CAS_CMP : EXEC;
                    end
                end
                EXEC: begin
                    done_q <= 1'b1;
                    cas_q  <= 1'b0;
                    state  <= DONE;
                end
                CAS_CMP: begin
                    match <= bus.alu_z;
                    state <= CAS_SWAP;
                end
                CAS_SWAP: begin
                    done_q <= 1'b1;
                    cas_q  <= match;
                    state  <= DONE;
                end
                DONE: begin
                    done_q <= 1'b0;
                    cas_q  <= 1'b0;
                    rdy_q  <= 1'b1;
                    state  <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    param_regfile #(
        .DATA_W (DATA_W),
        .NREGS  (NREGS)
    ) u_rf (
        .clk    (clk),
        .rst_n  (rst_n),
        .ra0    (a1),
        .ra1    (a2),
        .ra2    (a3),
        .rd0    (rd0),
        .rd1    (rd1),
        .rd2    (rd2),
        .we_a   (we_a),
        .wa_a   (wa_a),
        .wd_a   (wd_a),
        .we_b   (we_b),
        .wa_b   (wa_b),
        .wd_b   (wd_b),
        .last_q (reg_last)
    );
endmodule

// File: tb/tb_param_atomic_controller.sv
// Directed bench for param_atomic_controller with a behavioural external ALU.
module tb_param_atomic_controller;
    import atomic_alu_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        wr_en;
    logic [2:0]  wr_addr;
    logic [31:0] wr_data;
    logic [31:0] reg_last;
    logic [31:0] alu_y_m;

    int errors = 0;
    int checks = 0;

    param_atomic_controller_if #(.DATA_W(32), .NREGS(8)) bus ();

    param_atomic_controller #(.DATA_W(32), .NREGS(8)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .bus      (bus),
        .wr_en    (wr_en),
        .wr_addr  (wr_addr),
        .wr_data  (wr_data),
        .reg_last (reg_last)
    );

    always #5 clk = ~clk;

    always_comb begin
        alu_y_m = '0;
        case (bus.alu_op)
            OP_ADD:  alu_y_m = bus.alu_a + bus.alu_b;
            OP_SUB:  alu_y_m = bus.alu_a - bus.alu_b;
            OP_AND:  alu_y_m = bus.alu_a & bus.alu_b;
            OP_OR:   alu_y_m = bus.alu_a | bus.alu_b;
            OP_XOR:  alu_y_m = bus.alu_a ^ bus.alu_b;
            default: alu_y_m = '0;
        endcase
    end
    assign bus.alu_y = alu_y_m;
    assign bus.alu_z = (alu_y_m == 32'd0);

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [11:0] mk_cmd(input logic [2:0] op, input int x1, input int x2, input int x3);
        return {op, 3'(x1), 3'(x2), 3'(x3)};
    endfunction

    function automatic logic [31:0] rreg(input int i);
        return dut.u_rf.regs[i];
    endfunction

    task automatic host_write(input int addr, input logic [31:0] data);
        @(negedge clk);
        wr_en = 1'b1; wr_addr = 3'(addr); wr_data = data;
        @(posedge clk); #1;
        wr_en = 1'b0;
    endtask

    // Offers a command (optionally with a same-cycle host write), then follows it to completion.
    task automatic run_cmd(input logic [11:0] c, input logic hw, input int haddr, input logic [31:0] hdata,
                           output int lat, output int busy, output logic [2:0] e_op,
                           output logic [31:0] e_a, output logic [31:0] e_b, output logic succ);
        int n;
        lat = 0; busy = 0; succ = 1'b0; e_op = '0; e_a = '0; e_b = '0;
        @(negedge clk);
        bus.cmd_valid = 1'b1; bus.cmd = c;
        wr_en = hw; wr_addr = 3'(haddr); wr_data = hdata;
        n = 0;
        while (!bus.cmd_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (!bus.cmd_ready) check("accept_timeout", 64'(bus.cmd_ready), 64'd1);
        @(posedge clk); #1;
        bus.cmd_valid = 1'b0; wr_en = 1'b0;
        for (int k = 1; k <= 12; k++) begin
            @(negedge clk);
            if (k == 1) begin
                e_op = bus.alu_op; e_a = bus.alu_a; e_b = bus.alu_b;
            end
            if (bus.done && lat == 0) begin
                lat  = k;
                succ = bus.cas_success;
            end
            if (bus.cmd_ready) break;
            busy++;
        end
    endtask

    int          lat, busy, dones;
    logic [2:0]  e_op;
    logic [31:0] e_a, e_b;
    logic        succ;

    initial begin
        rst_n = 1'b0; wr_en = 1'b0; wr_addr = '0; wr_data = '0;
        bus.cmd_valid = 1'b0; bus.cmd = '0;

        // Reset for three cycles
        repeat (3) @(posedge clk);
        #1;
        check("rst_done", 64'(bus.done), 64'd0);
        check("rst_alu_a", 64'(bus.alu_a), 64'd0);
        @(negedge clk); rst_n = 1'b1;
        @(negedge clk);
        check("rst_ready", 64'(bus.cmd_ready), 64'd1);
        check("rst_done_after", 64'(bus.done), 64'd0);
        check("rst_reg_last", 64'(reg_last), 64'd0);
        check("rst_cas", 64'(bus.cas_success), 64'd0);
        for (int i = 0; i < 8; i++) check($sformatf("rst_R%0d", i), 64'(rreg(i)), 64'd0);

        // SUB 5-3 into R4
        host_write(1, 32'd5);
        host_write(2, 32'd3);
        run_cmd(mk_cmd(3'b001, 1, 2, 4), 1'b0, 0, 0, lat, busy, e_op, e_a, e_b, succ);
        check("sub_op", 64'(e_op), 64'd1);
        check("sub_alu_a", 64'(e_a), 64'd5);
        check("sub_alu_b", 64'(e_b), 64'd3);
        check("sub_R4", 64'(rreg(4)), 64'd2);
        check("sub_lat", 64'(lat), 64'd2);
        check("sub_busy", 64'(busy), 64'd2);
        check("sub_cas", 64'(succ), 64'd0);
        check("idle_alu_a", 64'(bus.alu_a), 64'd0);
        check("idle_alu_op", 64'(bus.alu_op), 64'd0);

        // ADD with a3==a1: operands are pre-write values
        run_cmd(mk_cmd(3'b000, 1, 2, 1), 1'b0, 0, 0, lat, busy, e_op, e_a, e_b, succ);
        check("add_self_a", 64'(e_a), 64'd5);
        check("add_self_R1", 64'(rreg(1)), 64'd8);
        check("add_self_lat", 64'(lat), 64'd2);

        // Host write on the accept cycle is seen by the command
        run_cmd(mk_cmd(3'b000, 6, 6, 7), 1'b1, 6, 32'd10, lat, busy, e_op, e_a, e_b, succ);
        check("same_cyc_a", 64'(e_a), 64'd10);
        check("same_cyc_R7", 64'(rreg(7)), 64'd20);
        check("same_cyc_last", 64'(reg_last), 64'd20);

        // CAS hit: swap R1 and R3
        host_write(1, 32'd7);
        host_write(2, 32'd7);
        host_write(3, 32'd9);
        run_cmd(mk_cmd(3'b111, 1, 2, 3), 1'b0, 0, 0, lat, busy, e_op, e_a, e_b, succ);
        check("cas_hit_op", 64'(e_op), 64'd1);
        check("cas_hit_R1", 64'(rreg(1)), 64'd9);
        check("cas_hit_R3", 64'(rreg(3)), 64'd7);
        check("cas_hit_succ", 64'(succ), 64'd1);
        check("cas_hit_lat", 64'(lat), 64'd3);
        check("cas_hit_busy", 64'(busy), 64'd3);

        // CAS miss: nothing changes
        host_write(1, 32'd7);
        host_write(2, 32'd6);
        host_write(3, 32'd9);
        run_cmd(mk_cmd(3'b111, 1, 2, 3), 1'b0, 0, 0, lat, busy, e_op, e_a, e_b, succ);
        check("cas_miss_R1", 64'(rreg(1)), 64'd7);
        check("cas_miss_R3", 64'(rreg(3)), 64'd9);
        check("cas_miss_succ", 64'(succ), 64'd0);
        check("cas_miss_lat", 64'(lat), 64'd3);

        // CAS hit with a1==a3 leaves registers intact
        host_write(2, 32'd7);
        run_cmd(mk_cmd(3'b111, 1, 2, 1), 1'b0, 0, 0, lat, busy, e_op, e_a, e_b, succ);
        check("cas_same_R1", 64'(rreg(1)), 64'd7);
        check("cas_same_R2", 64'(rreg(2)), 64'd7);
        check("cas_same_succ", 64'(succ), 64'd1);

        // cmd_valid held high, host write attempted during EXEC
        host_write(1, 32'd4);
        host_write(2, 32'd6);
        host_write(5, 32'h11);
        @(negedge clk);
        bus.cmd_valid = 1'b1; bus.cmd = mk_cmd(3'b000, 1, 2, 3);
        @(posedge clk); #1;
        @(negedge clk);
        check("hold_busy_exec", 64'(bus.cmd_ready), 64'd0);
        bus.cmd = mk_cmd(3'b000, 5, 5, 6);
        wr_en = 1'b1; wr_addr = 3'd5; wr_data = 32'hFF;
        @(negedge clk);
        wr_en = 1'b0;
        check("hold_done", 64'(bus.done), 64'd1);
        check("hold_busy_done", 64'(bus.cmd_ready), 64'd0);
        @(negedge clk);
        check("hold_ready_idle", 64'(bus.cmd_ready), 64'd1);
        check("hold_R5", 64'(rreg(5)), 64'h11);
        check("hold_R3", 64'(rreg(3)), 64'd10);
        @(posedge clk); #1;
        bus.cmd_valid = 1'b0;
        lat = 0;
        for (int k = 1; k <= 10; k++) begin
            @(negedge clk);
            if (bus.done && lat == 0) lat = k;
        end
        check("hold_second_lat", 64'(lat), 64'd2);
        check("hold_R6", 64'(rreg(6)), 64'h22);

        // Reset pulse during CAS_CMP aborts the command
        host_write(7, 32'h77);
        @(negedge clk);
        bus.cmd_valid = 1'b1; bus.cmd = mk_cmd(3'b111, 1, 1, 7);
        @(posedge clk); #1;
        bus.cmd_valid = 1'b0;
        @(negedge clk);
        check("abort_in_cmp", 64'(bus.alu_op), 64'd1);
        rst_n = 1'b0;
        #1;
        check("abort_done", 64'(bus.done), 64'd0);
        check("abort_alu_a", 64'(bus.alu_a), 64'd0);
        check("abort_last", 64'(reg_last), 64'd0);
        for (int i = 0; i < 8; i++) check($sformatf("abort_R%0d", i), 64'(rreg(i)), 64'd0);
        @(posedge clk);
        @(negedge clk); rst_n = 1'b1;
        dones = 0;
        for (int k = 1; k <= 6; k++) begin
            @(negedge clk);
            if (k == 1) check("abort_ready", 64'(bus.cmd_ready), 64'd1);
            if (bus.done) dones++;
        end
        check("abort_no_done", 64'(dones), 64'd0);
        check("abort_R1", 64'(rreg(1)), 64'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
